// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares the single UART transmitter between the power-on banner ROM and the
// Enigma cipher output path. After reset the banner (BANNER_LEN bytes, read
// combinationally from the ROM at ban_addr) is streamed. Cipher bytes are
// queued in a small FIFO at any time and are only issued once the banner has
// fully drained.
//
// Ports
//   clk           in   system clock (12 MHz)
//   rst_n         in   asynchronous active-low reset
//   ban_addr      out  banner ROM address (holds BANNER_LEN after the banner)
//   ban_data      in   banner byte at ban_addr
//   cipher_valid  in   cipher byte offered
//   cipher_data   in   cipher byte
//   cipher_ready  out  FIFO not full; byte accepted on valid && ready
//   tx_start      out  one-cycle pulse, uart_tx loads tx_data
//   tx_data       out  byte to transmit, stable while tx_start is high
//   tx_busy       in   uart_tx busy, rises the cycle after tx_start
//   banner_done   out  high once the final banner byte has drained
//   overflow      out  sticky, a cipher byte was dropped on a full FIFO
//   banner_replay in   (BANNER_REPLAY_EN only) one-cycle pulse requesting
//                      the banner be sent again
//
// Optional feature macro: BANNER_REPLAY_EN
//
// State table
//   state     | meaning
//   BAN_ISSUE | waiting for !tx_busy to issue the banner byte at ban_addr
//   GUARD     | one cycle after any issue; tx_start drops, tx_busy ignored
//   DRAIN     | waiting for uart_tx to finish the byte just issued
//   IDLE      | banner finished; issue queued cipher bytes
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int BANNER_LEN = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] ban_addr,
    input  logic [7:0] ban_data,
    input  logic       cipher_valid,
    input  logic [7:0] cipher_data,
    output logic       cipher_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       banner_done,
    output logic       overflow
`ifdef BANNER_REPLAY_EN
    ,
    input  logic       banner_replay
`endif
);

    typedef enum logic [1:0] {
        BAN_ISSUE = 2'd0,
        GUARD     = 2'd1,
        DRAIN     = 2'd2,
        IDLE      = 2'd3
    } state_t;

    // Banner position is kept one bit wider than the ROM address so that a
    // full 256-byte banner can still be told apart from "not started".
    localparam logic [8:0]     BAN_END = 9'(BANNER_LEN);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    state_t           state, state_nxt;
    logic [8:0]       ban_cnt, ban_cnt_nxt;
    logic             tx_start_nxt;
    logic [7:0]       tx_data_nxt;
    logic             banner_done_nxt;
    logic             pop;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             fifo_empty;

    // Only a 256-byte banner reaches bit 8; saturate so the address never
    // appears to wrap back to 0 once the banner is finished.
    assign ban_addr = ban_cnt[8] ? 8'hFF : ban_cnt[7:0];

    // -------------------------------------------------------------------------
    // Cipher FIFO
    // -------------------------------------------------------------------------
    assign cipher_ready = (count != DEPTH_C);
    assign push         = cipher_valid && cipher_ready;
    assign fifo_empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cipher_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (cipher_valid && !cipher_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Banner replay request latch
    // -------------------------------------------------------------------------
`ifdef BANNER_REPLAY_EN
    logic replay_pending;
    logic replay_clr;

    // Requests are only taken while a banner is not in progress; the clear
    // from IDLE wins over a pulse arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            replay_pending <= 1'b0;
        end else if (replay_clr) begin
            replay_pending <= 1'b0;
        end else if (banner_replay && banner_done) begin
            replay_pending <= 1'b1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Scheduler FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BAN_ISSUE;
            ban_cnt     <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            banner_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            ban_cnt     <= ban_cnt_nxt;
            tx_start    <= tx_start_nxt;
            tx_data     <= tx_data_nxt;
            banner_done <= banner_done_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        ban_cnt_nxt     = ban_cnt;
        tx_start_nxt    = 1'b0;
        tx_data_nxt     = tx_data;
        banner_done_nxt = banner_done;
        pop             = 1'b0;
`ifdef BANNER_REPLAY_EN
        replay_clr      = 1'b0;
`endif

        case (state)
            BAN_ISSUE: begin
                if (!tx_busy) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = ban_data;
                    ban_cnt_nxt  = ban_cnt + 9'd1;
                    state_nxt    = GUARD;
                end
            end

            // uart_tx raises busy one cycle late, so busy is not trusted here.
            GUARD: begin
                state_nxt = DRAIN;
            end

            DRAIN: begin
                if (!tx_busy) begin
                    if (ban_cnt < BAN_END) begin
                        state_nxt = BAN_ISSUE;
                    end else begin
                        banner_done_nxt = 1'b1;
                        state_nxt       = IDLE;
                    end
                end
            end

            IDLE: begin
`ifdef BANNER_REPLAY_EN
                if (replay_pending) begin
                    replay_clr      = 1'b1;
                    ban_cnt_nxt     = '0;
                    banner_done_nxt = 1'b0;
                    state_nxt       = BAN_ISSUE;
                end else
`endif
                if (!fifo_empty && !tx_busy) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = fifo_mem[rd_ptr];
                    pop          = 1'b1;
                    state_nxt    = GUARD;
                end
            end

            default: begin
                state_nxt = BAN_ISSUE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    localparam int BANNER_LEN = 16;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ban_addr;
    logic [7:0] ban_data;
    logic       cipher_valid;
    logic [7:0] cipher_data;
    logic       cipher_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       banner_done;
    logic       overflow;
`ifdef BANNER_REPLAY_EN
    logic       banner_replay;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .BANNER_LEN(BANNER_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PTR_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ban_addr(ban_addr),
        .ban_data(ban_data),
        .cipher_valid(cipher_valid),
        .cipher_data(cipher_data),
        .cipher_ready(cipher_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .banner_done(banner_done),
        .overflow(overflow)
`ifdef BANNER_REPLAY_EN
        ,
        .banner_replay(banner_replay)
`endif
    );

    // Banner ROM: combinational read. Low nibble = index so order is visible.
    logic [7:0] rom [256];
    assign ban_data = rom[ban_addr];

    // uart_tx model: busy for busy_len cycles starting the cycle after tx_start.
    int   busy_cnt = 0;
    int   busy_len = 1040;
    logic hold_busy;
    assign tx_busy = hold_busy || (busy_cnt != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              busy_cnt <= 0;
        else if (tx_start)       busy_cnt <= busy_len;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
    end

    // Transmit monitor: every tx_start pulse is captured with its data,
    // cycle number and the banner address seen during the pulse.
    int         cyc = 0;
    logic [7:0] cap_q[$];
    int         cap_cyc[$];
    int         cap_addr[$];
    int         width_errs = 0;
    logic       prev_start = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start) begin
            cap_q.push_back(tx_data);
            cap_cyc.push_back(cyc);
            cap_addr.push_back(int'(ban_addr));
        end
        if (tx_start && prev_start) width_errs <= width_errs + 1;
        prev_start <= tx_start;
    end

    // Reference: the ordered byte stream the transmitter must see.
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_caps(input string tag, input int n, input int budget);
        int k = 0;
        while (cap_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(cap_q.size() >= n), 32'd1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        cipher_valid = 1'b1;
        cipher_data  = b;
        @(negedge clk);
        cipher_valid = 1'b0;
    endtask

    task automatic chk_stream(input string tag, input int cap_base, input int exp_base, input int n);
        for (int i = 0; i < n; i++) begin
            if (cap_base + i < cap_q.size())
                chk(tag, 32'(cap_q[cap_base + i]), 32'(exp_q[exp_base + i]));
            else
                chk(tag, 32'hDEAD, 32'(exp_q[exp_base + i]));
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  t3v [4];
        logic [7:0]  b;
        int          n0, base, ebase, seen, k, acc, issued, min_gap;

        for (int i = 0; i < 256; i++) begin
            r      = $urandom;
            rom[i] = {r[7:4], 4'(i)};
        end
        t3v[0] = 8'h11; t3v[1] = 8'h22; t3v[2] = 8'h33; t3v[3] = 8'h44;

        rst_n        = 1'b0;
        cipher_valid = 1'b0;
        cipher_data  = 8'h00;
        hold_busy    = 1'b0;
`ifdef BANNER_REPLAY_EN
        banner_replay = 1'b0;
`endif

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_ban_addr", 32'(ban_addr), 32'd0);
        chk("rst_banner_done", 32'(banner_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(cipher_ready), 32'd1);

        // ---- banner with slow uart, cipher byte queued mid-banner ----
        for (int i = 0; i < BANNER_LEN; i++) exp_q.push_back(rom[i]);
        wait_caps("t1_wait3", 3, 5000);
        chk("t2_ready", 32'(cipher_ready), 32'd1);
        push_byte(8'h42);
        exp_q.push_back(8'h42);
        wait_caps("t1_wait16", BANNER_LEN, 20000);
        chk("t1_done_early", 32'(banner_done), 32'd0);
        wait_caps("t2_wait17", BANNER_LEN + 1, 3000);
        chk("t1_done", 32'(banner_done), 32'd1);
        chk("t1_addr_end", 32'(ban_addr), 32'(BANNER_LEN));
        chk_stream("t1_byte", 0, 0, BANNER_LEN + 1);
        for (int i = 0; i < BANNER_LEN; i++)
            chk("t1_addr", 32'(cap_addr[i]), 32'(i + 1));

        // ---- FIFO fill, overflow, ordered drain ----
        hold_busy = 1'b1;
        busy_len  = 25;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            chk("t3_ready", 32'(cipher_ready), 32'd1);
            push_byte(t3v[i]);
            exp_q.push_back(t3v[i]);
        end
        chk("t3_full", 32'(cipher_ready), 32'd0);
        chk("t3_ovf_before", 32'(overflow), 32'd0);
        push_byte(8'h55);
        chk("t3_ovf", 32'(overflow), 32'd1);
        n0 = cap_q.size();
        repeat (50) @(negedge clk);
        chk("t3_hold", 32'(cap_q.size()), 32'(n0));
        hold_busy = 1'b0;
        wait_caps("t3_wait", n0 + FIFO_DEPTH, 2000);
        repeat (200) @(negedge clk);
        chk("t3_no55", 32'(cap_q.size()), 32'(n0 + FIFO_DEPTH));
        chk_stream("t3_byte", n0, n0, FIFO_DEPTH);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // ---- busy held with one byte queued; latency after release ----
        hold_busy = 1'b1;
        b = 8'($urandom);
        push_byte(b);
        n0 = cap_q.size();
        repeat (1000) @(negedge clk);
        chk("t4_no_start", 32'(cap_q.size()), 32'(n0));
        hold_busy = 1'b0;
        @(negedge clk);
        chk("t4_latency", 32'(tx_start), 32'd1);
        chk("t4_data", 32'(tx_data), 32'(b));
        wait_caps("t4_cap", n0 + 1, 10);

        // ---- reset during GUARD of banner byte 7 ----
        busy_len = 40;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) push_byte(8'($urandom));
        chk("t5_ovf_set", 32'(overflow), 32'd1);
        seen = 0;
        k = 0;
        while (seen < 7 && k < 5000) begin
            @(negedge clk);
            k++;
            if (tx_start) seen++;
        end
        chk("t5_found7", 32'(seen), 32'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_start", 32'(tx_start), 32'd0);
        chk("t5_ovf_clr", 32'(overflow), 32'd0);
        chk("t5_fifo_empty", 32'(cipher_ready), 32'd1);
        chk("t5_addr0", 32'(ban_addr), 32'd0);
        chk("t5_done_clr", 32'(banner_done), 32'd0);
        @(negedge clk);
        base  = cap_q.size();
        ebase = exp_q.size();
        for (int i = 0; i < BANNER_LEN; i++) exp_q.push_back(rom[i]);
        rst_n = 1'b1;

        // ---- randomized: banner restart plus random cipher traffic ----
        acc = 0;
        k   = 0;
        while ((acc < 10 || cap_q.size() < base + BANNER_LEN + 10) && k < 20000) begin
            busy_len = $urandom_range(1, 40);
            issued = cap_q.size() - base - BANNER_LEN;
            if (issued < 0) issued = 0;
            if (acc < 10 && (acc - issued) < FIFO_DEPTH && $urandom_range(0, 7) == 0) begin
                chk("rnd_ready", 32'(cipher_ready), 32'd1);
                b = 8'($urandom);
                exp_q.push_back(b);
                acc++;
                push_byte(b);
            end else begin
                @(negedge clk);
            end
            k++;
        end
        chk("rnd_count", 32'(cap_q.size()), 32'(base + BANNER_LEN + 10));
        chk_stream("rnd_byte", base, ebase, BANNER_LEN + 10);
        for (int i = 0; i < BANNER_LEN; i++)
            chk("rnd_addr", 32'(cap_addr[base + i]), 32'(i + 1));
        min_gap = 1000000;
        for (int i = base + 1; i < cap_cyc.size(); i++)
            if (cap_cyc[i] - cap_cyc[i - 1] < min_gap) min_gap = cap_cyc[i] - cap_cyc[i - 1];
        chk("rnd_gap", 32'(min_gap >= 3), 32'd1);
        chk("rnd_ovf", 32'(overflow), 32'd0);
        chk("rnd_done", 32'(banner_done), 32'd1);
        chk("rnd_addr_end", 32'(ban_addr), 32'(BANNER_LEN));

`ifdef BANNER_REPLAY_EN
        // ---- banner replay with two bytes queued ----
        repeat (60) @(negedge clk);
        busy_len  = 50;
        hold_busy = 1'b1;
        n0    = cap_q.size();
        ebase = exp_q.size();
        b = 8'($urandom);
        exp_q.push_back(b);
        push_byte(b);
        for (int i = 0; i < BANNER_LEN; i++) exp_q.push_back(rom[i]);
        b = 8'($urandom);
        exp_q.push_back(b);
        push_byte(b);
        hold_busy = 1'b0;
        wait_caps("t6_b1", n0 + 1, 100);
        repeat (5) @(negedge clk);
        banner_replay = 1'b1;
        @(negedge clk);
        banner_replay = 1'b0;
        wait_caps("t6_all", n0 + BANNER_LEN + 2, 10000);
        repeat (100) @(negedge clk);
        chk("t6_count", 32'(cap_q.size()), 32'(n0 + BANNER_LEN + 2));
        chk_stream("t6_byte", n0, ebase, BANNER_LEN + 2);
        chk("t6_done", 32'(banner_done), 32'd1);
`endif

        chk("width", 32'(width_errs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
